// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   N-channel registered stream multiplexer with built-in arbitration.
//   One requesting channel is granted per cycle (fixed priority or
//   round-robin); the granted word, its channel index and its last flag are
//   captured in a single output register that holds under backpressure.
//
// Optional feature macro: STREAM_MUX_ARB_PKT_LOCK_EN
//   Defined   : packet lock FSM (UNLOCKED / LOCKED(c)); a multi-beat packet
//               keeps the grant on one channel until its in_last beat.
//   Undefined : per-beat arbitration, in_last ignored, out_last tied to 0.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed priority (lowest index), 1 = round-robin
//   in_valid   per-channel request
//   in_ready   per-channel grant, one-hot or zero
//   in_data    flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   in_last    per-channel end-of-packet marker
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
//   out_last   registered in_last of the selected beat

module stream_mux_arb #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_last
);

  // (base + ofs) mod CHANNELS, with ofs in [0, CHANNELS-1]
  function automatic logic [SEL_W-1:0] f_wrap(input logic [SEL_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  logic                             r_out_valid;
  logic [WIDTH-1:0]                 r_out_data;
  logic [SEL_W-1:0]                 r_out_sel;
  logic [SEL_W-1:0]                 r_ptr;

  logic [CHANNELS-1:0][WIDTH-1:0]   w_ch_data;
  logic [CHANNELS-1:0]              w_req;
  logic                             w_load_ok;
  logic                             w_gnt_vld;
  logic [SEL_W-1:0]                 w_gnt_idx;
  logic                             w_fire;
  logic                             w_ptr_adv;
  logic [SEL_W-1:0]                 w_ptr_nxt;

  // unflatten the channel data bus
  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_lane
      assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_load_ok = !r_out_valid || out_ready;

  // Arbiter. Loops run high-to-low so the last hit (smallest index or
  // smallest distance from the pointer) is the one that sticks.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (mode == 1'b0) begin
      for (int i = CHANNELS-1; i >= 0; i--) begin
        if (w_req[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int i = CHANNELS-1; i >= 0; i--) begin
        if (w_req[f_wrap(r_ptr, i)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = f_wrap(r_ptr, i);
        end
      end
    end
  end

  assign w_fire    = w_load_ok && w_gnt_vld;
  // rst_n gates the grant so nothing handshakes while reset is held
  assign in_ready  = (rst_n && w_fire) ? (CHANNELS'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : w_gnt_idx + SEL_W'(1);

`ifdef STREAM_MUX_ARB_PKT_LOCK_EN
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t      r_state, w_state_nxt;
  logic [SEL_W-1:0] r_lock_ch, w_lock_ch_nxt;
  logic             r_out_last;

  // while locked only the owning channel may be granted
  always_comb begin
    w_req = in_valid;
    if (r_state == LOCKED) w_req = in_valid & (CHANNELS'(1) << r_lock_ch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= UNLOCKED;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    case (r_state)
      UNLOCKED: if (w_fire && !in_last[w_gnt_idx]) begin
        w_state_nxt   = LOCKED;
        w_lock_ch_nxt = w_gnt_idx;
      end
      LOCKED:   if (w_fire && in_last[w_gnt_idx]) w_state_nxt = UNLOCKED;
      default:  w_state_nxt = UNLOCKED;
    endcase
  end

  // Pointer moves only when a packet ends (covers single-beat packets too),
  // so the next arbitration starts after the channel that just finished.
  assign w_ptr_adv = in_last[w_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out_last <= 1'b0;
    else if (w_fire) r_out_last <= in_last[w_gnt_idx];
  end

  assign out_last = r_out_last;
`else
  logic w_unused_last;

  assign w_req         = in_valid;
  assign w_ptr_adv     = 1'b1;
  assign out_last      = 1'b0;
  assign w_unused_last = ^in_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ch_data[w_gnt_idx];
        r_out_sel   <= w_gnt_idx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire && w_ptr_adv) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
